// File: rtl/light_package.sv
// Shared types and defaults for the traffic light controller and its
// sensor-conditioning front end.
//   colors         : light colour driven by the controller, fed back per channel
//   sensor_state_t : per-channel detector state
//   *_DEF          : default debounce / stuck-detector parameters
package light_package;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    PRESENT = 3'd2,
    FALL    = 3'd3,
    STUCK   = 3'd4
  } sensor_state_t;

  localparam int unsigned DEB_ON_DEF    = 3;
  localparam int unsigned DEB_OFF_DEF   = 2;
  localparam int unsigned STUCK_MAX_DEF = 60;
  localparam int unsigned NUM_CH        = 5;

  // A vehicle is considered present from debounced arrival until debounced departure.
  function automatic logic is_present(input sensor_state_t st);
    return (st == PRESENT) || (st == FALL) || (st == STUCK);
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One loop-detector channel: 2-flop synchroniser, debounce / stuck state
// machine and a call latch that remembers demand while the light is red.
//   clk, reset : clock, synchronous active-high reset
//   raw_i      : asynchronous loop-detector level
//   light_i    : current light for this channel
//   sensor_o   : conditioned demand (present or latched call)
//   fault_o    : detector declared stuck-on
module sensor_channel
  import light_package::*;
#(
  parameter int unsigned DEB_ON    = DEB_ON_DEF,
  parameter int unsigned DEB_OFF   = DEB_OFF_DEF,
  parameter int unsigned STUCK_MAX = STUCK_MAX_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  raw_i,
  input  colors light_i,
  output logic  sensor_o,
  output logic  fault_o
);

  localparam int unsigned CW = $clog2(STUCK_MAX + 1);
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] DON_LAST   = CW'(DEB_ON - 1);
  localparam logic [CW-1:0] DOFF_LAST  = CW'(DEB_OFF - 1);
  localparam logic [CW-1:0] SCNT_LAST  = CW'(STUCK_MAX - 1);

  logic          sync1_q, sync2_q;
  sensor_state_t state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          call_q, call_d;
  logic          sensor_q, fault_q;

  // Next-state, counter and call-latch logic.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    scnt_d  = scnt_q;
    call_d  = call_q;

    case (state_q)
      IDLE: begin
        dcnt_d = '0;
        scnt_d = '0;
        if (sync2_q) begin
          if (DEB_ON == 1) begin
            state_d = PRESENT;
          end else begin
            state_d = RISE;
            dcnt_d  = ONE;
          end
        end
      end
      RISE: begin
        if (!sync2_q) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DON_LAST) begin
          state_d = PRESENT;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      PRESENT: begin
        if (!sync2_q) begin
          if (DEB_OFF == 1) begin
            state_d = IDLE;
            dcnt_d  = '0;
            scnt_d  = '0;
          end else begin
            state_d = FALL;
            dcnt_d  = ONE;
          end
        end else if (scnt_q >= SCNT_LAST) begin
          state_d = STUCK;
          dcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + ONE;
        end
      end
      FALL: begin
        // A short dropout returns to PRESENT without losing stuck progress.
        if (sync2_q) begin
          state_d = PRESENT;
          dcnt_d  = '0;
        end else if (dcnt_q == DOFF_LAST) begin
          state_d = IDLE;
          dcnt_d  = '0;
          scnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
          if (scnt_q < SCNT_LAST) scnt_d = scnt_q + ONE;
        end
      end
      STUCK: begin
        // Only a debounced release gets out of STUCK.
        if (sync2_q) begin
          dcnt_d = '0;
        end else if (dcnt_q == DOFF_LAST) begin
          state_d = IDLE;
          dcnt_d  = '0;
          scnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
        scnt_d  = '0;
      end
    endcase

    // Green clears, yellow holds, red (or any unused code) latches demand.
    if (light_i == green) begin
      call_d = 1'b0;
    end else if (light_i == yellow) begin
      call_d = call_q;
    end else if (is_present(state_q)) begin
      call_d = 1'b1;
    end
  end

  // State and registered outputs; outputs track the next registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= IDLE;
      dcnt_q   <= '0;
      scnt_q   <= '0;
      call_q   <= 1'b0;
      sensor_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      scnt_q   <= scnt_d;
      call_q   <= call_d;
      sensor_q <= is_present(state_d) || call_d;
      fault_q  <= (state_d == STUCK);
    end
  end

  assign sensor_o = sensor_q;
  assign fault_o  = fault_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the five raw loop-detector inputs into clean *_sensor demands
// for the 3-street traffic light controller; one independent channel each.
//   clk, reset      : clock, synchronous active-high reset
//   raw_*           : asynchronous loop-detector levels
//   *_light         : current light per channel, fed back from the controller
//   *_sensor        : conditioned demand per channel
//   fault[4:0]      : stuck flags {ns, w_left, e_left, w_str, e_str}
module traffic_sensor_conditioner
  import light_package::*;
#(
  parameter int unsigned DEB_ON    = DEB_ON_DEF,
  parameter int unsigned DEB_OFF   = DEB_OFF_DEF,
  parameter int unsigned STUCK_MAX = STUCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              raw_e_str,
  input  logic              raw_w_str,
  input  logic              raw_e_left,
  input  logic              raw_w_left,
  input  logic              raw_ns,
  input  colors             e_str_light,
  input  colors             w_str_light,
  input  colors             e_left_light,
  input  colors             w_left_light,
  input  colors             ns_light,
  output logic              e_str_sensor,
  output logic              w_str_sensor,
  output logic              e_left_sensor,
  output logic              w_left_sensor,
  output logic              ns_sensor,
  output logic [NUM_CH-1:0] fault
);

  logic [NUM_CH-1:0] raw_v;
  logic [NUM_CH-1:0] sensor_v;
  colors             light_v [NUM_CH];

  assign raw_v      = {raw_ns, raw_w_left, raw_e_left, raw_w_str, raw_e_str};
  assign light_v[0] = e_str_light;
  assign light_v[1] = w_str_light;
  assign light_v[2] = e_left_light;
  assign light_v[3] = w_left_light;
  assign light_v[4] = ns_light;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_channel #(
      .DEB_ON   (DEB_ON),
      .DEB_OFF  (DEB_OFF),
      .STUCK_MAX(STUCK_MAX)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw_v[i]),
      .light_i (light_v[i]),
      .sensor_o(sensor_v[i]),
      .fault_o (fault[i])
    );
  end

  assign e_str_sensor  = sensor_v[0];
  assign w_str_sensor  = sensor_v[1];
  assign e_left_sensor = sensor_v[2];
  assign w_left_sensor = sensor_v[3];
  assign ns_sensor     = sensor_v[4];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed table and sequences plus a
// randomized run against a run-length based reference model.
module tb_traffic_sensor_conditioner;
  import light_package::*;

  localparam int unsigned DEB_ON    = 3;
  localparam int unsigned DEB_OFF   = 2;
  localparam int unsigned STUCK_MAX = 60;
  localparam logic [9:0]  LT_GREEN  = 10'h2AA;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw;
  logic [9:0] lts;
  logic [4:0] sensor;
  logic [4:0] fault;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   m_s1 [5], m_s2 [5], m_pres [5], m_stuck [5], m_call [5];
  int   m_hi [5], m_lo [5], m_pc [5];
  logic [4:0] m_sensor, m_fault;

  typedef struct {
    logic [4:0] raw;
    logic [9:0] lt;
    logic [4:0] exp_s;
  } vec_t;
  vec_t tv [17];

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .DEB_ON(DEB_ON), .DEB_OFF(DEB_OFF), .STUCK_MAX(STUCK_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_e_str    (raw[0]),
    .raw_w_str    (raw[1]),
    .raw_e_left   (raw[2]),
    .raw_w_left   (raw[3]),
    .raw_ns       (raw[4]),
    .e_str_light  (colors'(lts[1:0])),
    .w_str_light  (colors'(lts[3:2])),
    .e_left_light (colors'(lts[5:4])),
    .w_left_light (colors'(lts[7:6])),
    .ns_light     (colors'(lts[9:8])),
    .e_str_sensor (sensor[0]),
    .w_str_sensor (sensor[1]),
    .e_left_sensor(sensor[2]),
    .w_left_sensor(sensor[3]),
    .ns_sensor    (sensor[4]),
    .fault        (fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presence = DEB_ON consecutive synced highs, ends after DEB_OFF consecutive lows.
  // Stuck after STUCK_MAX cycles of accumulated presence.
  task automatic model_step();
    bit s, was;
    logic [1:0] lt;
    for (int i = 0; i < 5; i++) begin
      if (reset) begin
        m_s1[i] = 0; m_s2[i] = 0; m_pres[i] = 0; m_stuck[i] = 0; m_call[i] = 0;
        m_hi[i] = 0; m_lo[i] = 0; m_pc[i] = 0;
      end else begin
        s   = m_s2[i];
        was = m_pres[i];
        lt  = lts[2*i +: 2];
        if (!m_pres[i]) begin
          if (s) begin
            m_hi[i]++;
            if (m_hi[i] == int'(DEB_ON)) begin
              m_pres[i] = 1; m_lo[i] = 0; m_pc[i] = 0;
            end
          end else begin
            m_hi[i] = 0;
          end
        end else if (m_stuck[i]) begin
          if (s) m_lo[i] = 0;
          else begin
            m_lo[i]++;
            if (m_lo[i] == int'(DEB_OFF)) begin
              m_pres[i] = 0; m_stuck[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_pc[i] = 0;
            end
          end
        end else begin
          if (s) begin
            if (m_lo[i] == 0) begin
              if (m_pc[i] >= int'(STUCK_MAX) - 1) m_stuck[i] = 1;
              else m_pc[i]++;
            end
            m_lo[i] = 0;
          end else begin
            m_lo[i]++;
            if (m_lo[i] == int'(DEB_OFF)) begin
              m_pres[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_pc[i] = 0;
            end else if (m_lo[i] > 1 && m_pc[i] < int'(STUCK_MAX) - 1) begin
              m_pc[i]++;
            end
          end
        end
        if (lt == 2'd2) m_call[i] = 0;
        else if (lt != 2'd1 && was) m_call[i] = 1;
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
      m_sensor[i] = m_pres[i] | m_call[i];
      m_fault[i]  = m_stuck[i];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_sensor", 32'(sensor), 32'(m_sensor));
    chk("model_fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_all();
    raw = '0;
    lts = LT_GREEN;
    ticks(8);
    chk("clear_sensor", 32'(sensor), 32'h0);
  endtask

  int hold [5];

  initial begin
    reset = 1'b1;
    raw   = '1;
    lts   = 10'h000;

    // 1: reset with raws high, then rise latency
    ticks(2);
    chk("rst_sensor", 32'(sensor), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    reset = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("t1_rise", 32'(sensor[0]), (n == 5) ? 32'h1 : 32'h0);
    end
    clear_all();

    // 2: ns pulse table, ns light red, others green
    for (int r = 0; r < 17; r++) begin
      tv[r].lt    = 10'h0AA;
      tv[r].raw   = ((r <= 1) || (r >= 7 && r <= 9)) ? 5'h10 : 5'h00;
      tv[r].exp_s = (r >= 11 && r <= 14) ? 5'h10 : 5'h00;
    end
    tv[15].lt = LT_GREEN;
    for (int r = 0; r < 17; r++) begin
      raw = tv[r].raw;
      lts = tv[r].lt;
      tick();
      chk($sformatf("t2_row%0d", r), 32'(sensor), 32'(tv[r].exp_s));
    end
    clear_all();

    // 3: e_left with green, glitch immunity then debounced fall
    raw = 5'h04;
    for (int n = 1; n <= 5; n++) tick();
    chk("t3_present", 32'(sensor[2]), 32'h1);
    raw = 5'h00;
    tick();
    chk("t3_drop1_a", 32'(sensor[2]), 32'h1);
    raw = 5'h04;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("t3_drop1_b", 32'(sensor[2]), 32'h1);
    end
    raw = 5'h00;
    ticks(3);
    chk("t3_fall_hold", 32'(sensor[2]), 32'h1);
    tick();
    chk("t3_fall", 32'(sensor[2]), 32'h0);
    clear_all();

    // 4: w_str stuck detection and release
    raw = 5'h02;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n == 64) chk("t4_not_yet", 32'(fault), 32'h0);
      if (n == 65) begin
        chk("t4_stuck", 32'(fault), 32'h02);
        chk("t4_sensor", 32'(sensor[1]), 32'h1);
      end
    end
    raw = 5'h00;
    ticks(2);
    raw = 5'h02;
    tick();
    chk("t4_hold_fault", 32'(fault), 32'h02);
    tick();
    chk("t4_rel_fault", 32'(fault), 32'h0);
    chk("t4_rel_sensor", 32'(sensor[1]), 32'h0);
    clear_all();

    // 5: simultaneous arrival with mixed lights; w_str carries a prior call
    lts = 10'h2A2;
    raw = 5'h02;
    ticks(5);
    raw = 5'h00;
    ticks(5);
    chk("t5_prior_call", 32'(sensor), 32'h02);
    lts = 10'h124;
    raw = 5'h1F;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("t5_rise", 32'(sensor), (n == 5) ? 32'h1F : 32'h02);
    end
    raw = 5'h00;
    ticks(6);
    chk("t5_calls", 32'(sensor), 32'h0B);
    clear_all();

    // 6: reset while stuck with call latched
    lts = 10'h2A8;
    raw = 5'h01;
    ticks(70);
    chk("t6_stuck", 32'(fault), 32'h01);
    chk("t6_sensor", 32'(sensor), 32'h01);
    reset = 1'b1;
    tick();
    chk("t6_rst_sensor", 32'(sensor), 32'h0);
    chk("t6_rst_fault", 32'(fault), 32'h0);
    tick();
    chk("t6_rst_hold", 32'(sensor), 32'h0);
    reset = 1'b0;
    clear_all();

    // randomized run against the model
    for (int i = 0; i < 5; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          raw[i]  = ~raw[i];
          hold[i] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 90))
                                                  : int'($urandom_range(1, 6));
        end
        hold[i]--;
        if ($urandom_range(0, 7) == 0) lts[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
